mipi_frame_detector: RTL and testbench

- Monitors one MIPI CSI-2 byte-aligned lane stream after the D-PHY byte aligner.
- Tracks frame boundaries from short-packet headers and asserts a level flag while inside a frame (Frame Start seen, Frame End not yet seen).
- Downstream packet and pixel logic uses the flag to gate capture.

---
 rtl/mipi_csi_pkg.sv | 14 +
 rtl/mipi_frame_detector_if.sv | 8 +
 rtl/mipi_frame_detector.sv | 55 +++++
 tb/tb_mipi_frame_detector.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mipi_csi_pkg.sv
// mipi_csi_pkg: CSI-2 header constants and frame-detector FSM states
package mipi_csi_pkg;
  localparam logic [7:0] SYNC_BYTE      = 8'hB8;
  localparam logic [5:0] DT_FRAME_START = 6'h00;
  localparam logic [5:0] DT_FRAME_END   = 6'h01;
  localparam logic [5:0] DT_RAW10       = 6'h2B;
  localparam logic [5:0] DT_RAW12       = 6'h2C;
  localparam logic [5:0] DT_RAW14       = 6'h2D;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_DI, ST_SKIP} state_e;
  // Drops the virtual-channel bits so every VC decodes alike.
  function automatic logic [7:0] dt_of(input logic [7:0] di);
    return di & 8'h3F;
  endfunction
endpackage

// File: rtl/mipi_frame_detector_if.sv
// mipi_frame_detector_if: lane stream and frame flag bundle
interface mipi_frame_detector_if #(parameter int MIPI_GEAR = 16) (input logic clk);
  logic                 data_valid;
  logic [MIPI_GEAR-1:0] data_lane0;
  logic                 detected_frame_sync;
  modport master (input clk, output data_valid, data_lane0, input detected_frame_sync);
  modport slave  (input clk, input data_valid, data_lane0, output detected_frame_sync);
endinterface

// File: rtl/mipi_frame_detector.sv
// mipi_frame_detector: frame-in-progress flag from CSI-2 FS/FE short packet headers
module mipi_frame_detector
  import mipi_csi_pkg::*;
#(
  parameter int MIPI_GEAR = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 data_valid_i,
  input  logic [MIPI_GEAR-1:0] data_lane0_i,
  output logic                 detected_frame_sync_o
);
  state_e     state_q, state_d;
  logic       valid_q;
  logic       flag_q, flag_d;
  logic       burst_start, sync_ok, di_hit;
  logic [7:0] dt;
  always_comb begin
    burst_start = data_valid_i & ~valid_q;
    sync_ok     = data_lane0_i[7:0] == SYNC_BYTE;
    // The DI is the top byte of the word: byte 1 in gear 16, the only byte in gear 8.
    dt          = dt_of(data_lane0_i[MIPI_GEAR-1 -: 8]);
    state_d     = state_q;
    di_hit      = 1'b0;
    case (state_q)
      ST_IDLE: if (burst_start) begin
        if (MIPI_GEAR == 8) state_d = sync_ok ? ST_WAIT_DI : ST_SKIP;
        else begin
          state_d = ST_SKIP;
          di_hit  = sync_ok;
        end
      end
      ST_WAIT_DI: begin
        state_d = data_valid_i ? ST_SKIP : ST_IDLE;
        di_hit  = data_valid_i;
      end
      default: state_d = data_valid_i ? ST_SKIP : ST_IDLE;
    endcase
    flag_d = !di_hit                             ? flag_q :
             dt == {2'b00, DT_FRAME_START}       ? 1'b1   :
             dt == {2'b00, DT_FRAME_END}         ? 1'b0   : flag_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= data_valid_i;
      flag_q  <= flag_d;
    end
  end
  assign detected_frame_sync_o = flag_q;
endmodule

// File: tb/tb_mipi_frame_detector.sv
// tb_mipi_frame_detector: gear-16 and gear-8 detectors against a behavioural scoreboard
module tb_mipi_frame_detector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mipi_frame_detector_if #(.MIPI_GEAR(16)) bus16 (clk);
  mipi_frame_detector_if #(.MIPI_GEAR(8))  bus8  (clk);

  mipi_frame_detector #(.MIPI_GEAR(16)) u_g16 (
    .clk_i                 (clk),
    .reset_i               (rst),
    .data_valid_i          (bus16.data_valid),
    .data_lane0_i          (bus16.data_lane0),
    .detected_frame_sync_o (bus16.detected_frame_sync)
  );
  mipi_frame_detector #(.MIPI_GEAR(8)) u_g8 (
    .clk_i                 (clk),
    .reset_i               (rst),
    .data_valid_i          (bus8.data_valid),
    .data_lane0_i          (bus8.data_lane0),
    .detected_frame_sync_o (bus8.detected_frame_sync)
  );

  typedef struct {
    int   n;
    logic e16;
    logic e8;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int step_n = 0;

  logic m16_prev = 1'b0, m16_flag = 1'b0;
  logic m8_prev = 1'b0, m8_flag = 1'b0, m8_hdr = 1'b0;
  int   m8_idx = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0b exp=%0b", tag, obs, exp);
    end
  endtask

  // Drive one cycle on both lanes and push the flag values expected after the next edge.
  task automatic step(input logic r, input logic v16, input logic [15:0] w16,
                      input logic v8, input logic [7:0] w8);
    exp_t e;
    @(negedge clk);
    rst              = r;
    bus16.data_valid = v16;
    bus16.data_lane0 = v16 ? w16 : 16'hDEAD;
    bus8.data_valid  = v8;
    bus8.data_lane0  = v8 ? w8 : 8'hB8;
    if (r) begin
      m16_prev = 1'b0; m16_flag = 1'b0;
      m8_prev = 1'b0; m8_flag = 1'b0; m8_hdr = 1'b0; m8_idx = 0;
    end else begin
      if (v16 && !m16_prev && w16[7:0] == 8'hB8) begin
        if (w16[13:8] == 6'h00) m16_flag = 1'b1;
        if (w16[13:8] == 6'h01) m16_flag = 1'b0;
      end
      m16_prev = v16;
      if (v8) begin
        m8_idx = m8_prev ? m8_idx + 1 : 0;
        if (m8_idx == 0) m8_hdr = (w8 == 8'hB8);
        if (m8_idx == 1 && m8_hdr) begin
          if (w8[5:0] == 6'h00) m8_flag = 1'b1;
          if (w8[5:0] == 6'h01) m8_flag = 1'b0;
        end
      end
      m8_prev = v8;
    end
    e.n = step_n++;
    e.e16 = m16_flag;
    e.e8 = m8_flag;
    exp_q.push_back(e);
  endtask

  task automatic w16(input logic [15:0] w);
    step(1'b0, 1'b1, w, 1'b0, 8'h00);
  endtask
  task automatic w8(input logic [7:0] b);
    step(1'b0, 1'b0, 16'h0000, 1'b1, b);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("g16_step%0d", e.n), bus16.detected_frame_sync, e.e16);
      check($sformatf("g8_step%0d", e.n), bus8.detected_frame_sync, e.e8);
    end
  end

  initial begin
    logic [15:0] burst1 [9];
    logic [7:0]  raw_dt [3];
    int budget;
    bus16.data_valid = 1'b0; bus16.data_lane0 = '0;
    bus8.data_valid = 1'b0;  bus8.data_lane0 = '0;
    burst1 = '{16'h00B8, 16'h01B8, 16'h01B8, 16'h0201, 16'h0201,
               16'h0201, 16'h0201, 16'h01B8, 16'h0003};
    raw_dt = '{8'h2B, 8'h2C, 8'h2D};
    step(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    step(1'b1, 1'b0, 16'h0, 1'b0, 8'h0);
    idle(6);
    foreach (burst1[i]) w16(burst1[i]);
    idle(2);
    foreach (raw_dt[i]) begin
      w16({raw_dt[i], 8'hB8}); w16(16'h0201); w16(16'h0003);
      idle(2);
    end
    w16(16'h01B8); w16(16'h0205); w16(16'h0003);
    idle(2);
    w16(16'h0012); w16(16'h00B8);
    idle(2);
    w8(8'hB8); w8(8'h00); w8(8'h11); w8(8'h22);
    idle(1);
    w8(8'hB8); w8(8'h01); w8(8'h33);
    idle(1);
    w8(8'hB8); w8(8'h00); idle(1);
    w8(8'hB8);
    idle(2);
    w8(8'h00); w8(8'hB8); w8(8'h01);
    idle(2);
    w16(16'h00B8); w16(16'h0201);
    idle(1);
    step(1'b1, 1'b1, 16'h00B8, 1'b1, 8'hB8);
    idle(1);
    w16(16'h00B8); w16(16'h0201);
    step(1'b0, 1'b0, 16'h0, 1'b1, 8'hB8);
    w8(8'h00);
    idle(1);
    step(1'b0, 1'b1, 16'h0201, 1'b1, 8'h77);
    step(1'b1, 1'b1, 16'h0201, 1'b1, 8'h77);
    step(1'b0, 1'b1, 16'h00B8, 1'b1, 8'hB8);
    step(1'b0, 1'b1, 16'h0003, 1'b1, 8'h00);
    idle(3);
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(posedge clk); #2;
    if (exp_q.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
